serial_subtractor: RTL and testbench

//   Parametrised multi-cycle unsigned subtractor; successor to the single-bit half subtractor.

---
 rtl/serial_subtractor_pkg.sv | 19 +
 rtl/serial_subtractor_if.sv | 30 +++
 rtl/serial_subtractor_full_sub.sv | 13 +
 rtl/serial_subtractor.sv | 139 +++++++++++++
 tb/tb_serial_subtractor.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encoding and
// the digit-counter width helper.
package serial_sub_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE = 2'd0;
   localparam state_t ST_RUN  = 2'd1;
   localparam state_t ST_DONE = 2'd2;

   // clog2(n), but never narrower than one bit so a single-digit build still has a counter
   function automatic int cnt_width(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/response bundle for serial_subtractor. start/a/b/bin flow master->slave,
// busy/done/diff/bout and the FSM debug state flow slave->master.
interface serial_subtractor_if #(
   parameter int WIDTH = 8
) ();

   // Framing: a request is taken on a rising edge where start=1 and the slave is
   // idle (busy=0, done=0); a/b/bin are sampled on that edge only. done pulses
   // for one cycle when diff/bout become valid; they hold until the next taken start.
   logic                    start;
   logic [WIDTH-1:0]        a;
   logic [WIDTH-1:0]        b;
   logic                    bin;
   logic                    busy;
   logic                    done;
   logic [WIDTH-1:0]        diff;
   logic                    bout;
   serial_sub_pkg::state_t  dbg_state;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, dbg_state
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, dbg_state
   );

endinterface

// File: rtl/serial_subtractor_full_sub.sv
// One-bit full subtractor slice: d = x - y - bi, bo = borrow out.
module full_sub (
   input  logic x,
   input  logic y,
   input  logic bi,
   output logic d,
   output logic bo
);

   assign d  = x ^ y ^ bi;
   assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: diff = a - b - bin, DIGIT bits per clock, LSB first.
// Optional SERIAL_SUB_SAT_EN clamps diff to zero on underflow (bout still reports it).
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input logic                clk,
   input logic                rst,
   serial_subtractor_if.slave bus
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = cnt_width(NDIG);
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   generate
      if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
         $error("serial_subtractor: DIGIT must divide WIDTH and lie in 1..WIDTH");
      end
   endgenerate

   state_t            state_q;
   state_t            state_d;
   logic [WIDTH-1:0]  a_q;
   logic [WIDTH-1:0]  b_q;
   logic [WIDTH-1:0]  diff_q;
   logic [WIDTH-1:0]  diff_upd;
   logic              borrow_q;
   logic              bout_q;
   logic [CW-1:0]     cnt_q;
   logic              busy;
   logic              done;

   logic [DIGIT-1:0]  a_arr [NDIG];
   logic [DIGIT-1:0]  b_arr [NDIG];
   logic [DIGIT-1:0]  a_dig;
   logic [DIGIT-1:0]  b_dig;
   logic [DIGIT-1:0]  d_dig;
   logic [DIGIT:0]    br;

   logic accept;
   logic last;

   assign accept = (state_q == ST_IDLE) && bus.start;
   assign last   = (cnt_q == LAST);

   // Digit views of the held operands, and the result with only the current digit replaced
   generate
      for (genvar g = 0; g < NDIG; g++) begin : g_dig
         assign a_arr[g] = a_q[g*DIGIT +: DIGIT];
         assign b_arr[g] = b_q[g*DIGIT +: DIGIT];
         assign diff_upd[g*DIGIT +: DIGIT] =
            (cnt_q == CW'(g)) ? d_dig : diff_q[g*DIGIT +: DIGIT];
      end
   endgenerate

   assign a_dig = a_arr[cnt_q];
   assign b_dig = b_arr[cnt_q];
   assign br[0] = borrow_q;

   generate
      for (genvar i = 0; i < DIGIT; i++) begin : g_slice
         full_sub u_fs (
            .x  (a_dig[i]),
            .y  (b_dig[i]),
            .bi (br[i]),
            .d  (d_dig[i]),
            .bo (br[i+1])
         );
      end
   endgenerate

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (bus.start) state_d = ST_RUN;
         ST_RUN:  if (last)      state_d = ST_DONE;
         ST_DONE:                state_d = ST_IDLE;
         default:                state_d = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         ST_RUN:  busy = 1'b1;
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: operand latches, borrow chain register, digit counter, result
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         borrow_q <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
      end else if (accept) begin
         a_q      <= bus.a;
         b_q      <= bus.b;
         borrow_q <= bus.bin;
         cnt_q    <= '0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
      end else if (state_q == ST_RUN) begin
         diff_q   <= diff_upd;
         borrow_q <= br[DIGIT];
         cnt_q    <= last ? '0 : cnt_q + CW'(1);
         if (last) begin
            bout_q <= br[DIGIT];
`ifdef SERIAL_SUB_SAT_EN
            if (br[DIGIT]) diff_q <= '0;
`else
`endif
         end
      end
   end

   assign bus.busy      = busy;
   assign bus.done      = done;
   assign bus.diff      = diff_q;
   assign bus.bout      = bout_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: scoreboard on the 8/1 build plus
// directed checks on 8/4 and 1/1 builds. Honours SERIAL_SUB_SAT_EN in its model.
module tb_serial_subtractor;
   import serial_sub_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   start_cyc = 0;
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   serial_subtractor_if #(.WIDTH(8)) bus  ();
   serial_subtractor_if #(.WIDTH(8)) bus4 ();
   serial_subtractor_if #(.WIDTH(1)) bus1 ();

   serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
   serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
   serial_subtractor #(.WIDTH(1), .DIGIT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
      end
   endtask

   task automatic fail_now(input string name, input string why);
      checks++;
      failures++;
      $display("FAIL %s: %s", name, why);
   endtask

   // Reference: plain integer arithmetic, {bout, diff}
   function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic bin);
      int r;
      logic [7:0] d;
      logic bo;
      r  = int'(a) - int'(b) - int'(bin);
      bo = (r < 0);
      d  = 8'(r);
`ifdef SERIAL_SUB_SAT_EN
      if (bo) d = '0;
`endif
      return {bo, d};
   endfunction

   // Monitor: every done on the main build pops one expected result
   always @(negedge clk) begin
      logic [8:0] e;
      if (rst === 1'b0 && bus.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            fail_now("unexpected_done", $sformatf("got done with diff=0x%0h, required no done", bus.diff));
         end else begin
            e = exp_q.pop_front();
            check("result", {23'd0, bus.bout, bus.diff}, {23'd0, e});
         end
      end
   end

   task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic bin, input bit push);
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.bin   = bin;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      bus.start = 1'b0;
      if (push) exp_q.push_back(model(a, b, bin));
   endtask

   // Latency counts the accepted edge through the edge that closes the done cycle
   task automatic wait_done(input string name, output int lat, output int busy_n);
      lat = -1;
      busy_n = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.busy) busy_n++;
         if (bus.done) begin
            lat = cyc - start_cyc + 1;
            break;
         end
      end
      if (lat < 0) fail_now({name, "_timeout"}, "got no done within 60 cycles, required done");
   endtask

   task automatic op4(input logic [7:0] a, input logic [7:0] b, input logic bin);
      int s, lat;
      logic [8:0] e;
      e = model(a, b, bin);
      @(negedge clk);
      bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.bin = bin;
      @(posedge clk);
      #1;
      s = cyc;
      bus4.start = 1'b0;
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus4.done) begin lat = cyc - s + 1; break; end
      end
      check("d4_latency", lat, 3);
      check("d4_result", {23'd0, bus4.bout, bus4.diff}, {23'd0, e});
   endtask

   task automatic op1(input logic a, input logic b, input logic d_req, input logic bo_req);
      int s, lat;
      @(negedge clk);
      bus1.start = 1'b1; bus1.a = a; bus1.b = b; bus1.bin = 1'b0;
      @(posedge clk);
      #1;
      s = cyc;
      bus1.start = 1'b0;
      lat = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus1.done) begin lat = cyc - s + 1; break; end
      end
      check("w1_latency", lat, 2);
      check($sformatf("w1_diff_%0b%0b", a, b), bus1.diff, d_req);
      check($sformatf("w1_bout_%0b%0b", a, b), bus1.bout, bo_req);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, busy_n, s0;
      logic [8:0] e;
      logic [7:0] ra, rb;
      logic       rbin;
      logic       sat_d01;

      rst = 1'b1;
      bus.start = 1'b0;  bus.a = '0;  bus.b = '0;  bus.bin = 1'b0;
      bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.bin = 1'b0;
      bus1.start = 1'b0; bus1.a = '0; bus1.b = '0; bus1.bin = 1'b0;
      repeat (3) @(posedge clk);
      // Start held during reset must be ignored (reset wins)
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_diff", bus.diff, 0);
      check("rst_bout", bus.bout, 0);
      check("rst_state", bus.dbg_state, ST_IDLE);
      @(negedge clk);
      rst = 1'b0;

      // Basic, underflow and corner operands with latency and busy length
      issue(8'h05, 8'h03, 1'b0, 1'b1);
      wait_done("t1", lat, busy_n);
      check("t1_latency", lat, 9);
      check("t1_busy_cycles", busy_n, 8);
      issue(8'h03, 8'h05, 1'b0, 1'b1);
      wait_done("t2", lat, busy_n);
      issue(8'h00, 8'h00, 1'b1, 1'b1);
      wait_done("t3a", lat, busy_n);
      issue(8'hFF, 8'hFF, 1'b0, 1'b1);
      wait_done("t3b", lat, busy_n);

      // Start pulsed mid-run is ignored; result holds after done
      issue(8'h55, 8'h12, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      bus.a = 8'h10;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done("t4", lat, busy_n);
      check("t4_latency", lat, 9);
      e = model(8'h55, 8'h12, 1'b0);
      repeat (4) @(negedge clk);
      check("t4_hold_diff", bus.diff, e[7:0]);
      check("t4_hold_bout", bus.bout, e[8]);

      // Start held high: second op begins in the first idle cycle after done
      @(negedge clk);
      bus.start = 1'b1; bus.a = 8'h9A; bus.b = 8'hC3; bus.bin = 1'b1;
      exp_q.push_back(model(8'h9A, 8'hC3, 1'b1));
      exp_q.push_back(model(8'h9A, 8'hC3, 1'b1));
      @(posedge clk);
      #1;
      start_cyc = cyc;
      s0 = cyc;
      wait_done("held1", lat, busy_n);
      check("held1_latency", lat, 9);
      @(posedge clk);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("held_gap", cyc - s0, 10);
      start_cyc = cyc;
      wait_done("held2", lat, busy_n);
      check("held2_latency", lat, 9);

      // Reset mid-run aborts with no done pulse
      issue(8'hFF, 8'h00, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      check("t5_partial_diff", bus.diff, 8'h07);
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("t5_busy", bus.busy, 0);
      check("t5_done", bus.done, 0);
      check("t5_diff", bus.diff, 0);
      check("t5_bout", bus.bout, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (15) @(negedge clk);

      // Randomized operations with idle gaps
      for (int n = 0; n < 20; n++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         rbin = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         issue(ra, rb, rbin, 1'b1);
         wait_done("rand", lat, busy_n);
         if (n < 4) check("rand_latency", lat, 9);
      end

      // Other widths/digit sizes
      op4(8'h80, 8'h01, 1'b0);
      op4(8'h12, 8'h34, 1'b1);
`ifdef SERIAL_SUB_SAT_EN
      sat_d01 = 1'b0;
`else
      sat_d01 = 1'b1;
`endif
      op1(1'b0, 1'b0, 1'b0, 1'b0);
      op1(1'b0, 1'b1, sat_d01, 1'b1);
      op1(1'b1, 1'b0, 1'b1, 1'b0);
      op1(1'b1, 1'b1, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
